// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and state encoding for the UART frame receiver.
// Holds the start-of-frame byte, error cause codes and FSM states.
package uart_frame_rx_pkg;

    localparam logic [7:0] SOF = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_LEN,
        S_PAY,
        S_CHK,
        S_HOLD
    } state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter for uart_frame_rx.
// Used only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 75000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Framed-packet receiver: SOF, OP, LEN, payload, XOR checksum.
// Optional inter-byte timeout when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 75000,
    parameter int AW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    output logic          frame_valid,
    output logic [7:0]    frame_op,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    input  logic          frame_ack,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    if ((1 << AW) < MAX_LEN) begin : g_aw_chk
        $error("uart_frame_rx: 2**AW must be >= MAX_LEN");
    end

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_par_chk
        $error("uart_frame_rx: parameter out of range");
    end

    state_t     state, state_n;
    logic       pop;
    logic       err_set;
    logic [1:0] code_n;
    logic [7:0] op_q, len_q, idx, chk;
    logic [7:0] mem [2**AW];

    assign pop     = !reset && !rx_empty && (state != S_HOLD);
    assign rd_uart = pop;

`ifdef UART_FRAME_TIMEOUT_EN
    logic tmo;

    uart_frame_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (pop || state == S_IDLE),
        .run    (state inside {S_OP, S_LEN, S_PAY, S_CHK}),
        .expired(tmo)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            err      <= err_set;
            err_code <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        code_n  = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                if (pop && r_data == SOF) state_n = S_OP;
            end
            S_OP: begin
                if (pop) state_n = S_LEN;
            end
            S_LEN: begin
                if (pop) begin
                    if (r_data > MAX_B) begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        code_n  = ERR_LEN;
                    end else if (r_data == 8'h00) begin
                        state_n = S_CHK;
                    end else begin
                        state_n = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (pop && idx == len_q - 8'd1) state_n = S_CHK;
            end
            S_CHK: begin
                if (pop) begin
                    if ((chk ^ r_data) == 8'h00) begin
                        state_n = S_HOLD;
                    end else begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        code_n  = ERR_CHK;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        // Timer only runs mid-frame, so this cannot fire in IDLE or HOLD.
        if (tmo && !pop) begin
            state_n = S_IDLE;
            err_set = 1'b1;
            code_n  = ERR_TMO;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= 8'h00;
            len_q <= 8'h00;
            idx   <= 8'h00;
            chk   <= 8'h00;
        end else if (pop) begin
            unique case (state)
                S_OP: begin
                    op_q <= r_data;
                    chk  <= r_data;
                end
                S_LEN: begin
                    len_q <= r_data;
                    chk   <= chk ^ r_data;
                    idx   <= 8'h00;
                end
                S_PAY: begin
                    chk <= chk ^ r_data;
                    idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; contents are only meaningful in HOLD.
    always_ff @(posedge clk) begin
        if (pop && state == S_PAY) mem[idx[AW-1:0]] <= r_data;
    end

    assign buf_data    = mem[buf_addr];
    assign frame_valid = (state == S_HOLD);
    assign frame_op    = op_q;
    assign frame_len   = len_q;

endmodule
